slot_mem_responder: RTL
=======================

// Module: slot_mem_responder
// PURPOSE
// - Memory-side responder for slot mappers: consumes a mapper's ram_cs/mem_addr/mem_rnw request and runs one
//   read or write per CPU bus cycle on a ready-acknowledged RAM port.
// - Returns read data and holds the Z80 in wait until the access completes.
// - Sits between the slot mapper mux and the SDRAM/BRAM arbiter port.
// PARAMETERS
// - ADDR_W          27  mapper/RAM address width
// - DATA_W          8   data width
// - TIMEOUT_CYCLES  64  WAIT cycles without ram_ready before abort (>=2)
// PORTS
// - clk_sys      in   1       system clock; all logic on rising edge
// - reset        in   1       synchronous, active-high reset
// - cpu_mreq     in   1       CPU memory request
// - cpu_dout     in   DATA_W  CPU write data
// - cpu_din      out  DATA_W  read data to CPU (registered)
// - cpu_wait     out  1       CPU wait request
// - ram_cs       in   1       mapper chip select
// - mem_addr     in   ADDR_W  mapper address (all-ones when idle)
// - mem_rnw      in   1       1=read, 0=write
// - ram_addr     out  ADDR_W  RAM address (registered)
// - ram_din      out  DATA_W  RAM write data (registered)
// - ram_rd       out  1       one-cycle read strobe
// - ram_wr       out  1       one-cycle write strobe
// - ram_ready    in   1       one-cycle completion ack from RAM
// - ram_dout     in   DATA_W  RAM read data, valid with ram_ready
// - timeout_err  out  1       one-cycle pulse on timeout abort
// BEHAVIOUR
// - req = ram_cs & cpu_mreq; access starts on IDLE with req=1 (one access per bus cycle, not per clock).
// - FSM states: IDLE, ISSUE, WAIT, DONE.
//   - IDLE -> ISSUE when req: latch ram_addr<=mem_addr, ram_din<=cpu_dout, rnw<=mem_rnw.
//   - ISSUE (1 cycle): ram_rd=rnw, ram_wr=~rnw; go to WAIT; clear timeout counter.
//   - WAIT: ram_ready is sampled here only (ignored during ISSUE).
//     - On ram_ready: if rnw, cpu_din<=ram_dout. Go to DONE if req is still high, else IDLE.
//     - Count each WAIT cycle without ready. At TIMEOUT_CYCLES: cpu_din<=8'hFF (reads only), timeout_err=1
//       for 1 cycle, same DONE/IDLE choice.
//   - DONE: hold until req=0, then IDLE. A new bus cycle therefore needs req to drop first.
// - cpu_wait = req & (state!=DONE). It is combinational so the CPU sees wait in the same cycle as req.
// - Minimum latency: req -> cpu_wait low = 3 clocks (IDLE, ISSUE, WAIT with ready).
// - Read/write strobes are exactly 1 cycle wide; never both high.
// - ram_addr/ram_din are stable from ISSUE until leaving WAIT.
// - req dropping during ISSUE/WAIT: the access still completes, so RAM never sees an abandoned strobe.
//   The FSM then returns to IDLE, not DONE.
// - ram_ready and timeout in the same cycle: ready wins; no error pulse.
// - Write with ram_ready: cpu_din unchanged.
// - mem_addr all-ones with ram_cs=1 is a legal address and is treated normally.
// - Reset, including mid-access:
//   - FSM returns to IDLE; counter is cleared.
//   - ram_rd/ram_wr/timeout_err=0, cpu_din=8'hFF, ram_addr=0, ram_din=0.
//   - cpu_wait follows the formula.
// CONFIGURATION
// - SLOT_MEM_RESP_RDCACHE_EN defined: adds a one-entry read cache (address, data, valid).
//   - A read in IDLE whose mem_addr hits a valid entry loads cpu_din from the cache and goes straight to DONE.
//     No strobe is issued; cpu_wait drops after 1 clock.
//   - Every completed read fills the entry.
//   - A write to the cached address updates the cached data.
//   - A timeout or reset invalidates the entry.
// - Undefined: no cache; every access issues a RAM strobe.
// TESTING
// - Read: req, addr 27'h0001234, ready 2 clk after ISSUE with dout 8'h5A.
//   -> one ram_rd pulse, cpu_din=8'h5A, cpu_wait low 1 clk after ready, FSM in DONE until req drops.
// - Write: cpu_dout 8'hC3, addr 27'h0000010, immediate ready.
//   -> one ram_wr pulse, ram_din=8'hC3, ram_rd never high, cpu_din unchanged.
// - Timeout: read, no ready for 64 WAIT cycles.
//   -> timeout_err 1-cycle pulse, cpu_din=8'hFF, next access still works.
// - Held req: keep ram_cs/cpu_mreq high 20 clk after completion -> exactly one strobe total.
// - Mid-op: drop req during WAIT, then give ready -> FSM returns to IDLE, no second strobe.
//   Separately, reset during WAIT -> strobes 0, cpu_din=8'hFF, FSM in IDLE.
// - With SLOT_MEM_RESP_RDCACHE_EN: read 8'h77 at A, release, read A again -> no second ram_rd, cpu_din=8'h77.
//   Then write 8'h11 to A and read A -> cpu_din=8'h11 with no ram_rd.

Source files
------------

// File: rtl/slot_mem_responder.sv
// Memory-side responder: runs one RAM read/write per CPU bus cycle and holds the Z80 in wait until done.
// Optional one-entry read cache enabled by defining SLOT_MEM_RESP_RDCACHE_EN.
module slot_mem_responder #(
    parameter int ADDR_W         = 27,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              cpu_mreq,
    input  logic [DATA_W-1:0] cpu_dout,
    output logic [DATA_W-1:0] cpu_din,
    output logic              cpu_wait,
    input  logic              ram_cs,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rnw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_rd,
    output logic              ram_wr,
    input  logic              ram_ready,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              timeout_err
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t             state_q;
    logic               rnw_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               req;
    logic               cache_hit;
    logic [DATA_W-1:0]  cache_rd_data;

    assign req      = ram_cs & cpu_mreq;
    assign cpu_wait = req & (state_q != S_DONE);

`ifdef SLOT_MEM_RESP_RDCACHE_EN
    logic [ADDR_W-1:0] cache_addr_q;
    logic [DATA_W-1:0] cache_data_q;
    logic              cache_valid_q;
    logic              ready_done;
    logic              timeout_hit;

    assign ready_done    = (state_q == S_WAIT) & ram_ready;
    assign timeout_hit   = (state_q == S_WAIT) & ~ram_ready & (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign cache_hit     = mem_rnw & cache_valid_q & (mem_addr == cache_addr_q);
    assign cache_rd_data = cache_data_q;

    // Entry tracks the last completed read; writes to that address keep it coherent.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= '0;
        end else if (timeout_hit) begin
            cache_valid_q <= 1'b0;
        end else if (ready_done) begin
            if (rnw_q) begin
                cache_addr_q  <= ram_addr;
                cache_data_q  <= ram_dout;
                cache_valid_q <= 1'b1;
            end else if (cache_valid_q && (ram_addr == cache_addr_q)) begin
                cache_data_q  <= ram_din;
            end
        end
    end
`else
    assign cache_hit     = 1'b0;
    assign cache_rd_data = '1;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rnw_q       <= 1'b1;
            cnt_q       <= '0;
            ram_addr    <= '0;
            ram_din     <= '0;
            ram_rd      <= 1'b0;
            ram_wr      <= 1'b0;
            timeout_err <= 1'b0;
            cpu_din     <= '1;
        end else begin
            ram_rd      <= 1'b0;
            ram_wr      <= 1'b0;
            timeout_err <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        if (cache_hit) begin
                            cpu_din <= cache_rd_data;
                            state_q <= S_DONE;
                        end else begin
                            ram_addr <= mem_addr;
                            ram_din  <= cpu_dout;
                            rnw_q    <= mem_rnw;
                            ram_rd   <= mem_rnw;
                            ram_wr   <= ~mem_rnw;
                            state_q  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Ready is checked first so it beats a timeout landing in the same cycle.
                    if (ram_ready) begin
                        if (rnw_q) cpu_din <= ram_dout;
                        state_q <= req ? S_DONE : S_IDLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                        if (rnw_q) cpu_din <= '1;
                        timeout_err <= 1'b1;
                        state_q     <= req ? S_DONE : S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!req) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
